bk_mp_add_seq: RTL

- Multi-precision add/subtract sequencer that time-shares one 32-bit Brent-Kung adder (`bentkung`: a, b, cin -> s, cout).
- Accepts WORDS×32-bit operands through a valid/ready handshake and feeds one 32-bit word pair per cycle through the adder, least-significant word first.
- Chains the carry through a register and returns the full-width result through a second valid/ready handshake.
- Sits between the arithmetic request source and result consumer in the datapath.

---
 rtl/bk_mp_add_seq_pkg.sv | 15 +
 rtl/bk_mp_add_seq_if.sv | 34 +++
 rtl/bk_mp_add_seq_bentkung.sv | 47 ++++
 rtl/bk_mp_add_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bk_mp_add_seq_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package bk_mp_add_pkg;

  localparam int WORD_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bk_mp_add_seq_if.sv
// Request/result bus of bk_mp_add_seq: one request channel, one result channel.
interface bk_mp_add_seq_if
  import bk_mp_add_pkg::*;
#(
  parameter int WORDS = 4
);

  // Both channels use strict valid/ready: a transfer happens on a rising edge where
  // valid && ready; once valid is high the source holds it and its payload stable
  // until that edge, and valid never depends combinationally on ready.
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_op;
  logic                      in_cin;
  logic [WORDS*WORD_W-1:0]   in_a;
  logic [WORDS*WORD_W-1:0]   in_b;

  logic                      out_valid;
  logic                      out_ready;
  logic [WORDS*WORD_W-1:0]   out_sum;
  logic                      out_cout;
  logic                      out_zero;

  modport master (
    output in_valid, in_op, in_cin, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_zero
  );

  modport slave (
    input  in_valid, in_op, in_cin, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_zero
  );

endinterface

// File: rtl/bk_mp_add_seq_bentkung.sv
// 32-bit Brent-Kung parallel-prefix adder (a, b, cin -> s, cout), purely combinational.
module bentkung (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic [31:0] p_bit;
  logic [31:0] gg;
  logic [31:0] pp;
  logic [32:0] c;

  always_comb begin
    p_bit = a ^ b;
    gg    = a & b;
    pp    = p_bit;

    // Up-sweep: node (k+1)*2^(l+1)-1 absorbs the group just below it.
    for (int l = 0; l < 5; l++) begin
      for (int k = 0; k < (32 >> (l + 1)); k++) begin
        gg[(k+1)*(2<<l)-1] = gg[(k+1)*(2<<l)-1]
                           | (pp[(k+1)*(2<<l)-1] & gg[(k+1)*(2<<l)-1-(1<<l)]);
        pp[(k+1)*(2<<l)-1] = pp[(k+1)*(2<<l)-1] & pp[(k+1)*(2<<l)-1-(1<<l)];
      end
    end

    // Down-sweep fills the remaining prefixes so every node spans bit 0 upward.
    for (int l = 3; l >= 0; l--) begin
      for (int k = 0; k < (32 >> (l + 1)) - 1; k++) begin
        gg[(k+1)*(2<<l)+(1<<l)-1] = gg[(k+1)*(2<<l)+(1<<l)-1]
                                  | (pp[(k+1)*(2<<l)+(1<<l)-1] & gg[(k+1)*(2<<l)-1]);
        pp[(k+1)*(2<<l)+(1<<l)-1] = pp[(k+1)*(2<<l)+(1<<l)-1] & pp[(k+1)*(2<<l)-1];
      end
    end

    c[0] = cin;
    for (int i = 0; i < 32; i++) begin
      c[i+1] = gg[i] | (pp[i] & cin);
    end
  end

  assign s    = p_bit ^ c[31:0];
  assign cout = c[32];

endmodule

// File: rtl/bk_mp_add_seq.sv
// Multi-precision add/subtract sequencer: one 32-bit bentkung adder, one word per cycle,
// LSW first. Optional performance counters under BK_MP_ADD_PERF_CNT_EN.
module bk_mp_add_seq
  import bk_mp_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bk_mp_add_seq_if.slave       bus,
  output state_t               dbg_state
`ifdef BK_MP_ADD_PERF_CNT_EN
  ,
  output logic [31:0]          ops_done,
  output logic [31:0]          busy_cycles
`endif
);

  localparam int W     = WORDS * WORD_W;
  localparam int IDX_W = $clog2(WORDS) + 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       bx_q, bx_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [WORD_W-1:0]  add_a, add_b, add_s;
  logic               add_cout;
  logic               last_word;

  assign last_word = (idx_q == IDX_W'(WORDS - 1));

  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        add_a = a_q[k*WORD_W +: WORD_W];
        add_b = bx_q[k*WORD_W +: WORD_W];
      end
    end
  end

  bentkung u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    bx_d        = bx_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          // Subtract is A + ~B + cin, so B is inverted once at capture.
          a_d        = bus.in_a;
          bx_d       = bus.in_b ^ {W{bus.in_op}};
          carry_d    = bus.in_cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < WORDS; k++) begin
          if (idx_q == IDX_W'(k)) begin
            sum_d[k*WORD_W +: WORD_W] = add_s;
          end
        end
        carry_d = add_cout;
        if (last_word) begin
          cout_d      = add_cout;
          zero_d      = (sum_d == '0);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      bx_q        <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      bx_q        <= bx_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_zero  = zero_q;
  assign dbg_state     = state_q;

`ifdef BK_MP_ADD_PERF_CNT_EN
  logic [31:0] ops_done_q, ops_done_d;
  logic [31:0] busy_q, busy_d;

  always_comb begin
    ops_done_d = ops_done_q;
    busy_d     = busy_q;
    if (state_q == DONE && bus.out_ready) begin
      ops_done_d = ops_done_q + 32'd1;
    end
    if (state_q == RUN && busy_q != 32'hFFFF_FFFF) begin
      busy_d = busy_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_done_q <= '0;
      busy_q     <= '0;
    end else begin
      ops_done_q <= ops_done_d;
      busy_q     <= busy_d;
    end
  end

  assign ops_done    = ops_done_q;
  assign busy_cycles = busy_q;
`endif

endmodule
